skew_operand_buf: RTL and testbench

Parametrised, double-buffered operand staging memory for the systolic array. It holds a DIM×DIM signed operand tile, loaded a row or a column per write, and streams it as a diagonally skewed wavefront: lane k is delayed k cycles. It generalises the A-side and B-side buffers in one block, with a runtime load orientation, a ping-pong bank so the next tile loads while the current one streams, and per-lane valid flags. It sits between the host-write path and the array's left (A) or top (B) edge.

---
 rtl/skew_operand_buf.sv | 120 ++++++++++++
 tb/tb_skew_operand_buf.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/skew_operand_buf.sv
// Double-buffered DIMxDIM operand tile that streams as a diagonally skewed wavefront
// (lane k delayed k beats), with ping-pong banks so the next tile loads while one streams.
module skew_operand_buf #(
  parameter  int BITS_AB = 8,
  parameter  int DIM     = 8,
  localparam int CW      = $clog2(2*DIM-1),
  localparam int IW      = $clog2(DIM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   col_mode,
  input  logic [IW-1:0]          wr_idx,
  input  logic [DIM*BITS_AB-1:0] wr_data,
  input  logic                   start,
  output logic                   start_ready,
  output logic [DIM*BITS_AB-1:0] out_data,
  output logic [DIM-1:0]         out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_bank_sel
);

  localparam logic [0:0]    IDLE   = 1'b0;
  localparam logic [0:0]    STREAM = 1'b1;
  localparam logic [CW-1:0] LAST   = CW'(2*DIM-2);

  logic signed [BITS_AB-1:0] mem [2][DIM][DIM];
  logic                      wr_bank;
  logic                      rd_bank;
  logic [0:0]                state;
  logic [CW-1:0]             t;
  logic                      accept;
  logic [DIM*BITS_AB-1:0]    beat_data;
  logic [DIM-1:0]            beat_valid;
  logic [BITS_AB-1:0]        first_elem;

  assign start_ready = (state == IDLE) | done;
  assign accept      = start & start_ready;
  assign wr_bank_sel = wr_bank;

  // Writes always target wr_bank as it stands before this edge, so a write issued
  // together with an accepted start lands in the bank being launched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < DIM; r++)
          for (int c = 0; c < DIM; c++)
            mem[b][r][c] <= '0;
    end else if (wr_en) begin
      for (int j = 0; j < DIM; j++) begin
        if (!col_mode)
          mem[wr_bank][wr_idx][IW'(j)] <= wr_data[j*BITS_AB +: BITS_AB];
        else
          mem[wr_bank][IW'(j)][wr_idx] <= wr_data[j*BITS_AB +: BITS_AB];
      end
    end
  end

  always_comb begin
    beat_data  = '0;
    beat_valid = '0;
    for (int k = 0; k < DIM; k++) begin
      if (int'(t) >= k && int'(t) - k < DIM) begin
        beat_valid[k]                    = 1'b1;
        beat_data[k*BITS_AB +: BITS_AB]  = mem[rd_bank][IW'(k)][IW'(int'(t) - k)];
      end
    end
  end

  // A back-to-back launch emits beat 0 on the accept edge itself, so element (0,0)
  // of the new bank must bypass a write landing on that same edge.
  assign first_elem = (wr_en && wr_idx == '0) ? wr_data[BITS_AB-1:0] : mem[wr_bank][0][0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      t         <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      out_data  <= '0;
      out_valid <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (accept) begin
      rd_bank <= wr_bank;
      wr_bank <= ~wr_bank;
      state   <= STREAM;
      done    <= 1'b0;
      if (done) begin
        out_data  <= {{((DIM-1)*BITS_AB){1'b0}}, first_elem};
        out_valid <= DIM'(1);
        busy      <= 1'b1;
        t         <= CW'(1);
      end else begin
        out_data  <= '0;
        out_valid <= '0;
        busy      <= 1'b0;
        t         <= '0;
      end
    end else if (state == STREAM) begin
      out_data  <= beat_data;
      out_valid <= beat_valid;
      busy      <= 1'b1;
      done      <= (t == LAST);
      if (t == LAST) begin
        state <= IDLE;
        t     <= '0;
      end else begin
        t <= t + 1'b1;
      end
    end else begin
      out_data  <= '0;
      out_valid <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_skew_operand_buf.sv
// Randomised and directed bench for skew_operand_buf at DIM=4, checked every cycle
// against a beat-timeline model of the tile banks.
module tb_skew_operand_buf;

  localparam int D     = 4;
  localparam int B     = 8;
  localparam int LASTB = 2*D-2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wr_en = 1'b0;
  logic           col_mode = 1'b0;
  logic [1:0]     wr_idx = '0;
  logic [D*B-1:0] wr_data = '0;
  logic           start = 1'b0;
  logic           start_ready;
  logic [D*B-1:0] out_data;
  logic [D-1:0]   out_valid;
  logic           busy;
  logic           done;
  logic           wr_bank_sel;

  skew_operand_buf #(.BITS_AB(B), .DIM(D)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .col_mode(col_mode), .wr_idx(wr_idx),
    .wr_data(wr_data), .start(start), .start_ready(start_ready), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .done(done), .wr_bank_sel(wr_bank_sel)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: bank contents, bank pointers, and which beat is on the outputs
  // (-2 idle, -1 waiting for the first beat, 0..LASTB showing that beat).
  logic [B-1:0] mm [2][D][D];
  int wrb, rdb, phase;

  task automatic modelReset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < D; r++)
        for (int c = 0; c < D; c++)
          mm[b][r][c] = '0;
    wrb = 0;
    rdb = 0;
    phase = -2;
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [D*B-1:0] ed;
    logic [D-1:0]   ev;
    ed = '0;
    ev = '0;
    if (phase >= 0) begin
      for (int k = 0; k < D; k++) begin
        int c;
        c = phase - k;
        if (c >= 0 && c < D) begin
          ev[k] = 1'b1;
          ed[k*B +: B] = mm[rdb][k][c];
        end
      end
    end
    cmp("out_data", 64'(out_data), 64'(ed));
    cmp("out_valid", 64'(out_valid), 64'(ev));
    cmp("busy", 64'(busy), 64'(phase >= 0));
    cmp("done", 64'(done), 64'(phase == LASTB));
    cmp("wr_bank_sel", 64'(wr_bank_sel), 64'(wrb));
    cmp("start_ready", 64'(start_ready), 64'(phase == -2 || phase == LASTB));
  endtask

  task automatic applyStimulus(input logic we, input logic cm, input int idx,
                               input logic [D*B-1:0] data, input logic st);
    logic ready;
    @(negedge clk);
    wr_en = we;
    col_mode = cm;
    wr_idx = 2'(idx);
    wr_data = data;
    start = st;
    @(posedge clk);
    ready = (phase == -2) || (phase == LASTB);
    if (we) begin
      for (int j = 0; j < D; j++) begin
        if (!cm) mm[wrb][idx][j] = data[j*B +: B];
        else     mm[wrb][j][idx] = data[j*B +: B];
      end
    end
    if (st && ready) begin
      rdb = wrb;
      wrb = 1 - wrb;
      phase = (phase == LASTB) ? 0 : -1;
    end else if (phase == -1) phase = 0;
    else if (phase == LASTB) phase = -2;
    else if (phase >= 0) phase++;
    #1;
    checkOutput();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b0);
  endtask

  function automatic logic [D*B-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
    return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // Launch the write bank and pin beats 0, 3 and 6 of the 10r+c matrix.
  task automatic runAndPin(input string tag);
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1);
    idleCycle();
    cmp({tag, "_beat0_data"}, 64'(out_data), 64'h0);
    cmp({tag, "_beat0_valid"}, 64'(out_valid), 64'h1);
    repeat (3) idleCycle();
    cmp({tag, "_beat3_data"}, 64'(out_data), 64'h1E150C03);
    cmp({tag, "_beat3_valid"}, 64'(out_valid), 64'hF);
    repeat (3) idleCycle();
    cmp({tag, "_beat6_data"}, 64'(out_data), 64'h21000000);
    cmp({tag, "_beat6_valid"}, 64'(out_valid), 64'h8);
    cmp({tag, "_beat6_done"}, 64'(done), 64'h1);
    repeat (2) idleCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput();
    cmp("reset_wr_bank_sel", 64'(wr_bank_sel), 64'h0);
    rst = 1'b0;
    repeat (3) idleCycle();

    for (int r = 0; r < D; r++)
      applyStimulus(1'b1, 1'b0, r, pack4(10*r, 10*r+1, 10*r+2, 10*r+3), 1'b0);
    runAndPin("row");

    for (int c = 0; c < D; c++)
      applyStimulus(1'b1, 1'b1, c, pack4(c, 10+c, 20+c, 30+c), 1'b0);
    runAndPin("col");

    // Bank 0 still holds the row-loaded tile; a start pulse mid-stream must be dropped.
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1);
    repeat (3) idleCycle();
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1);
    cmp("ignored_start_bank", 64'(wr_bank_sel), 64'h1);
    repeat (3) idleCycle();
    cmp("ignored_start_done", 64'(done), 64'h1);
    repeat (2) idleCycle();

    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1);
    cmp("pingpong_first_bank", 64'(wr_bank_sel), 64'h0);
    for (int r = 0; r < D; r++)
      applyStimulus(1'b1, 1'b0, r, pack4(-(10*r), -(10*r+1), -(10*r+2), -(10*r+3)), 1'b0);
    repeat (3) idleCycle();
    applyStimulus(1'b0, 1'b0, 0, '0, 1'b1);
    cmp("pingpong_y0_busy", 64'(busy), 64'h1);
    cmp("pingpong_y0_valid", 64'(out_valid), 64'h1);
    cmp("pingpong_second_bank", 64'(wr_bank_sel), 64'h1);
    idleCycle();
    cmp("pingpong_y1_data", 64'(out_data), 64'h0000F6FF);
    cmp("pingpong_y1_valid", 64'(out_valid), 64'h3);

    #2;
    rst = 1'b1;
    wr_en = 1'b0;
    start = 1'b0;
    modelReset();
    #1;
    checkOutput();
    cmp("midrun_reset_valid", 64'(out_valid), 64'h0);
    cmp("midrun_reset_bank", 64'(wr_bank_sel), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 0, pack4(-128, 127, 0, 1), 1'b1);
    idleCycle();
    cmp("samecycle_beat0", 64'(out_data), 64'h00000080);
    idleCycle();
    cmp("samecycle_beat1", 64'(out_data), 64'h0000007F);
    cmp("samecycle_beat1_valid", 64'(out_valid), 64'h3);
    repeat (6) idleCycle();

    for (int n = 0; n < 600; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, D-1)), 32'($urandom),
                    ($urandom_range(0, 3) == 0));
    end
    repeat (10) idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
